// File: rtl/n64_pkg.sv
// n64_pkg: shared state encoding and protocol constants for the N64 poll controller
package n64_pkg;
  typedef enum logic [2:0] {IDLE, TX_BIT, TX_STOP, RX_EDGE, RX_SAMPLE, DONE} n64_poll_state_t;
  localparam logic [7:0] N64_CMD_POLL = 8'h01;
  localparam int N64_RESP_BITS = 32;
  localparam int N64_Q_LOW0 = 3;
  localparam int N64_Q_LOW1 = 1;
endpackage

// File: rtl/n64_line_sync.sv
// n64_line_sync: 2-flop synchronizer for the pad line plus a registered falling-edge pulse
module n64_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic data_in,
  output logic line,
  output logic fall
);
  logic s1, prev;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      line <= 1'b1;
      prev <= 1'b1;
      fall <= 1'b0;
    end else begin
      s1 <= data_in;
      line <= s1;
      prev <= line;
      fall <= prev & ~line;
    end
  end
endmodule

// File: rtl/n64_poll_ctrl.sv
// n64_poll_ctrl: sends the N64 poll command and decodes the 32-bit reply; N64_POLL_AUTO_EN adds periodic self-polling
module n64_poll_ctrl
  import n64_pkg::*;
#(
  parameter int BIT_CYCLES = 200,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int POLL_PERIOD = 833333
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        data_in,
  output logic        data_oe,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  input  logic        resp_ready,
  output logic        timeout
);
  localparam int Q = BIT_CYCLES / 4;
  localparam int CMAX = BIT_CYCLES > TIMEOUT_CYCLES ? BIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  n64_poll_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, low_len;
  logic [2:0] bit_idx, bit_idx_n;
  logic [4:0] rx_cnt, rx_cnt_n;
  logic [31:0] shift, shift_n, resp_n;
  logic line, fall, go;

  n64_line_sync u_sync (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
    .line(line),
    .fall(fall)
  );

`ifdef N64_POLL_AUTO_EN
  localparam int PW = $clog2(POLL_PERIOD);
  logic [PW-1:0] poll_cnt;
  logic tick;
  assign tick = poll_cnt == PW'(POLL_PERIOD - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) poll_cnt <= '0;
    else poll_cnt <= tick ? '0 : poll_cnt + 1'b1;
  end
  assign go = start | tick;
`else
  assign go = start;
`endif

  assign low_len = N64_CMD_POLL[bit_idx] ? CW'(N64_Q_LOW1 * Q) : CW'(N64_Q_LOW0 * Q);
  assign busy = (state != IDLE) && (state != DONE);
  assign resp_valid = state == DONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      rx_cnt <= '0;
      shift <= '0;
      resp_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_idx_n;
      rx_cnt <= rx_cnt_n;
      shift <= shift_n;
      resp_data <= resp_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    bit_idx_n = bit_idx;
    rx_cnt_n = rx_cnt;
    shift_n = shift;
    resp_n = resp_data;
    data_oe = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (go) begin
          state_n = TX_BIT;
          bit_idx_n = 3'd7;
        end
      end
      TX_BIT: begin
        data_oe = cnt < low_len;
        if (cnt == CW'(BIT_CYCLES - 1)) begin
          cnt_n = '0;
          bit_idx_n = bit_idx - 3'd1;
          state_n = bit_idx == 3'd0 ? TX_STOP : TX_BIT;
        end
      end
      TX_STOP: begin
        data_oe = 1'b1;
        if (cnt == CW'(Q - 1)) begin
          cnt_n = '0;
          rx_cnt_n = '0;
          state_n = RX_EDGE;
        end
      end
      RX_EDGE: begin
        if (fall) begin
          cnt_n = '0;
          state_n = RX_SAMPLE;
        end else if (cnt == CW'(TIMEOUT_CYCLES)) begin
          timeout = 1'b1;
          state_n = IDLE;
        end
      end
      RX_SAMPLE: begin
        // sample mid-cell: a '1' cell has released by now, a '0' cell is still low
        if (cnt == CW'(2 * Q - 1)) begin
          cnt_n = '0;
          shift_n = {shift[30:0], line};
          rx_cnt_n = rx_cnt + 5'd1;
          state_n = rx_cnt == 5'(N64_RESP_BITS - 1) ? DONE : RX_EDGE;
          resp_n = rx_cnt == 5'(N64_RESP_BITS - 1) ? {shift[30:0], line} : resp_data;
        end
      end
      DONE: begin
        cnt_n = '0;
        if (resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_n64_poll_ctrl.sv
// tb_n64_poll_ctrl: directed bench with an open-drain controller reply model
module tb_n64_poll_ctrl;
  localparam int BC = 16;
  localparam int TO = 64;
  localparam int PP = 1000;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, resp_ready = 1'b0, pull = 1'b0;
  logic data_in, data_oe, busy, resp_valid, timeout;
  logic [31:0] resp_data;
  int errors = 0, checks = 0, to_pulses = 0, cyc = 0;

  always #5 clk = ~clk;
  assign data_in = ~(data_oe | pull);
  always @(posedge clk) begin
    cyc++;
    if (timeout) to_pulses++;
  end

  n64_poll_ctrl #(.BIT_CYCLES(BC), .TIMEOUT_CYCLES(TO), .POLL_PERIOD(PP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .data_in(data_in),
    .data_oe(data_oe),
    .busy(busy),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .resp_ready(resp_ready),
    .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // starts a poll and checks the 132-cycle command waveform; returns on the release cycle
  task automatic tx_check(input string tag);
    logic [131:0] got, expv;
    int b, ph;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    for (int c = 0; c < 132; c++) begin
      b = c / 16;
      ph = c % 16;
      got[c] = data_oe;
      expv[c] = b < 7 ? ph < 12 : b == 7 ? ph < 4 : 1'b1;
      @(negedge clk);
    end
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s_wave: got %h expected %h", tag, got, expv);
    end
    chk({tag, "_release"}, data_oe, 0);
  endtask

  task automatic reply(input logic [31:0] w, input int nbits);
    logic b;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      b = w[31 - i];
      pull = 1'b1;
      repeat (b ? 4 : 12) @(negedge clk);
      pull = 1'b0;
      repeat (b ? 12 : 4) @(negedge clk);
    end
    pull = 1'b1;
    repeat (4) @(negedge clk);
    pull = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic decode(input string tag, input logic [31:0] w);
    int t0;
    tx_check(tag);
    t0 = to_pulses;
    reply(w, 32);
    chk({tag, "_valid"}, resp_valid, 1);
    chk({tag, "_data"}, resp_data, w);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_no_timeout"}, to_pulses, t0);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk) resp_ready = 1'b1;
    @(negedge clk) resp_ready = 1'b0;
    chk({tag, "_valid_low"}, resp_valid, 0);
  endtask

  task automatic main_test();
    int first, n, busy_after, w;
    logic seen_valid, ok;
    logic [31:0] d;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_oe", data_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    @(negedge clk);
    tx_check("tx");
    first = -1;
    n = 0;
    busy_after = -1;
    seen_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (timeout) begin
        n++;
        if (first < 0) first = k;
      end
      if (first >= 0 && k == first + 1) busy_after = busy;
      seen_valid |= resp_valid;
      @(negedge clk);
    end
    chk("noreply_to_time", first, TO);
    chk("noreply_to_count", n, 1);
    chk("noreply_busy_fall", busy_after, 0);
    chk("noreply_valid", seen_valid, 0);
    decode("dec_a", 32'h8000_00FF);
    handshake("dec_a");
    decode("dec_b", 32'h3C5A_A5C3);
    d = resp_data;
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk) start = (i % 7) == 3;
      ok &= resp_valid && resp_data === d && !data_oe && !busy;
    end
    start = 1'b0;
    chk("bp_stable", ok, 1);
    @(negedge clk) begin
      resp_ready = 1'b1;
      start = 1'b1;
    end
    @(negedge clk) begin
      resp_ready = 1'b0;
      start = 1'b0;
    end
    chk("bp_idle_valid", resp_valid, 0);
    chk("bp_idle_busy", busy, 0);
    @(negedge clk);
    chk("bp_start_ignored", busy, 0);
    tx_check("trunc");
    reply(32'hFFFF_FFFF, 20);
    w = 0;
    seen_valid = 1'b0;
    while (!timeout && w < 200) begin
      @(negedge clk);
      seen_valid |= resp_valid;
      w++;
    end
    chk("trunc_timeout", timeout, 1);
    chk("trunc_valid", seen_valid, 0);
    @(negedge clk);
    chk("trunc_busy", busy, 0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (17) @(negedge clk);
    chk("mid_tx_low", data_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_oe", data_oe, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", resp_valid, 0);
    chk("arst_timeout", timeout, 0);
    chk("arst_data", resp_data, 0);
    @(negedge clk) rst_n = 1'b1;
    decode("dec_c", 32'hFFFF_FFFE);
    handshake("dec_c");
  endtask

  task automatic auto_test();
    int rises[$];
    int t0, w;
    logic pb, ok;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    pb = 1'b0;
    repeat (3500) begin
      @(negedge clk);
      if (busy && !pb) rises.push_back(cyc);
      pb = busy;
    end
    chk("auto_rises", rises.size(), 3);
    for (int i = 1; i < rises.size(); i++) chk("auto_period", rises[i] - rises[i-1], PP);
    resp_ready = 1'b0;
    w = 0;
    do begin
      pb = busy;
      @(negedge clk);
      w++;
    end while (!(busy && !pb) && w < 1200);
    t0 = cyc;
    chk("auto_tick", busy, 1);
    repeat (132) @(negedge clk);
    reply(32'hA5A5_0F0F, 32);
    chk("auto_valid", resp_valid, 1);
    ok = 1'b1;
    repeat (2500) begin
      @(negedge clk);
      ok &= !busy && resp_valid && resp_data === 32'hA5A5_0F0F;
    end
    chk("auto_drop", ok, 1);
    resp_ready = 1'b1;
    w = 0;
    do begin
      pb = busy;
      @(negedge clk);
      w++;
    end while (!(busy && !pb) && w < 1200);
    chk("auto_resume", busy, 1);
    chk("auto_phase", (cyc - t0) % PP, 0);
  endtask

  initial begin
`ifdef N64_POLL_AUTO_EN
    auto_test();
`else
    main_test();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/n64_poll_ctrl.md
# n64_poll_ctrl

Host-side sequencer for one N64 controller port. It transmits the 8-bit poll command (0x01) and stop bit on the open-drain data line, then times and decodes the controller's 32-bit button/stick response. The decoded word goes to downstream logic over a valid/ready handshake. It sits between the pad (open-drain buffer driven by `data_oe`) and the button consumer, replacing free-running shift capture with protocol-correct sequencing.

## Interface
- `BIT_CYCLES`, 200: clk cycles per 4 us bit period (50 MHz); must be a multiple of 4; Q = BIT_CYCLES/4.
- `TIMEOUT_CYCLES`, 1000: maximum cycles to wait for any response falling edge.
- `POLL_PERIOD`, 833333: cycles between automatic polls (used only with auto-poll compiled in).

- `clk` in 1: single clock, all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request one poll; accepted only in IDLE.
- `data_in` in 1: raw pad line level; asynchronous, synchronized internally.
- `data_oe` out 1: 1 = pull line low; 0 = release (pull-up makes it high).
- `busy` out 1: high from accepted start until return to IDLE or DONE.
- `resp_valid` out 1: response word available.
- `resp_data` out 32: response, first received bit in [31].
- `resp_ready` in 1: consumer accepts `resp_data` when `resp_valid & resp_ready`.
- `timeout` out 1: one-cycle pulse when the response is absent or truncated.

## Operation
- States: IDLE, TX_BIT, TX_STOP, RX_EDGE, RX_SAMPLE, DONE.
- IDLE: `start` (or the auto tick) moves to TX_BIT with cmd = 8'h01 and bit index 7.
- TX_BIT: commands go MSB first.
  - '0' bit: `data_oe` = 1 for 3Q, then 0 for 1Q.
  - '1' bit: `data_oe` = 1 for 1Q, then 0 for 3Q.
  - After bit 0, go to TX_STOP.
- TX_STOP: `data_oe` = 1 for 1Q, then released. Go to RX_EDGE with rx count 0 and timeout counter cleared.
- RX_EDGE: wait for a falling edge on the synchronized line.
  - On an edge, go to RX_SAMPLE.
  - If the counter reaches TIMEOUT_CYCLES, pulse `timeout` and go to IDLE.
  - The timeout counter restarts at every bit.
- RX_SAMPLE: wait 2Q cycles after edge detection, then sample.
  - high = 1, low = 0.
  - Shift the sample into the LSB of the shift register (first bit ends in [31]).
  - After 32 samples, go to DONE; the controller stop bit is ignored.
  - Otherwise return to RX_EDGE.
- DONE: `resp_data` is loaded and `resp_valid` = 1.
  - Both hold stable until `resp_valid & resp_ready`, then go to IDLE.
  - `start` is ignored in DONE, including in the handshake cycle.
- `data_oe` is 0 in every state except the low phases of TX_BIT and TX_STOP.
- Reset values: `data_oe` 0, `busy` 0, `resp_valid` 0, `resp_data` 0, `timeout` 0, state IDLE.
- Reset mid-operation: all outputs clear immediately (asynchronously), and the line is released. A partial response is discarded.
- A truncated response (fewer than 32 edges) ends in a timeout. No partial word is ever presented.

## Timing
- Input path: 2-flop synchronizer, then a 1-flop edge detector. Edge detection lags the pad by 3 cycles; the sample point is 2Q + 3 cycles after the pad falling edge.
- TX duration is exactly 8·BIT_CYCLES + Q cycles from the first `data_oe` rise.
- `data_oe` rises on the cycle after the `start`-accept edge. `busy` rises in the same cycle.
- `resp_valid` rises the cycle after the 32nd sample.
- `timeout` rises the cycle the counter hits TIMEOUT_CYCLES; state is IDLE on the next cycle.

## Configuration
- `N64_POLL_AUTO_EN`
  - Defined: an internal counter issues a start tick every POLL_PERIOD cycles. `start` is ORed with the tick. A tick that arrives while not in IDLE is dropped, not queued. The counter resets to 0 on `rst_n` and free-runs.
  - Undefined: no counter is built, POLL_PERIOD is unused, and only `start` initiates polls.

## Structure
- Package `n64_pkg`:
  - state enum `n64_poll_state_t`.
  - `N64_CMD_POLL` = 8'h01.
  - `N64_RESP_BITS` = 32.
  - quarter-phase constants for 0/1 low times (3, 1) in units of Q.
- Sub-module `n64_line_sync`: 2-flop synchronizer plus registered falling-edge pulse. Ports: `clk`, `rst_n`, `data_in`, `line`, `fall`. It resets to line = 1.
- Everything else (FSM, quarter/bit/timeout counters, shift register) lives in `n64_poll_ctrl`.

## Test plan
Bench uses BIT_CYCLES = 16 (Q = 4), TIMEOUT_CYCLES = 64, and a controller model.
- **TX waveform.** Stimulus: `start` pulse. Required: `data_oe` = seven '0' bits (12 low, 4 high), one '1' bit (4 low, 12 high), then stop (4 low, then release), 132 cycles total.
- **Decode.** Stimulus: model replies 32'h8000_00FF with the correct 1 us/3 us cells. Required: `resp_valid` = 1 and `resp_data` = 32'h8000_00FF; `timeout` never pulses.
- **No reply.** Stimulus: model silent. Required: `timeout` pulses once, 64 cycles after TX_STOP release; `resp_valid` stays 0; `busy` falls on the next cycle.
- **Backpressure.** Stimulus: `resp_ready` = 0 for 50 cycles after `resp_valid`, plus `start` pulses during that window. Required: `resp_data` and `resp_valid` are stable, no new TX occurs, and IDLE is reached one cycle after `resp_ready` = 1.
- **Reset mid-TX.** Stimulus: `rst_n` low mid-TX, during a low phase. Required: `data_oe` goes 0 without waiting for a clk edge; all outputs are at reset values; the next `start` produces a full, clean 132-cycle TX.
- **Auto poll.** Build with `N64_POLL_AUTO_EN` and POLL_PERIOD = 1000. Required: `data_oe` first rises every 1000 cycles with `start` tied 0, and ticks are dropped while `resp_ready` is held 0.
